// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter with ownership lock in front of a 1-cycle-read memory.
// Optional MEM_PORT_ARB_PERF_EN adds saturating conflict / lock-stall counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_lock_stall,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);
    localparam logic [1:0] LK_NONE = 2'd0, LK_A = 2'd1, LK_B = 2'd2;
    logic [1:0]        lk;
    logic              last, rd_pend, rd_port, gnt, we, lock;
    logic [ADDR_W-1:0] addr;
    always_comb begin
        // last=1 means B was granted most recently, so A wins the next tie
        a_gnt    = !rst && a_req && (lk == LK_A || (lk == LK_NONE && (!b_req || last)));
        b_gnt    = !rst && b_req && (lk == LK_B || (lk == LK_NONE && (!a_req || !last)));
        gnt      = a_gnt || b_gnt;
        we       = b_gnt ? b_we : a_we;
        lock     = b_gnt ? b_lock : a_lock;
        addr     = b_gnt ? b_addr : a_addr;
        r_en     = gnt && !we;
        w_en     = gnt && we;
        r_addr   = r_en ? addr : '0;
        w_addr   = w_en ? addr : '0;
        w_data   = w_en ? (b_gnt ? b_wdata : a_wdata) : '0;
        a_rvalid = !rst && rd_pend && !rd_port;
        b_rvalid = !rst && rd_pend && rd_port;
        a_rdata  = a_rvalid ? r_data : '0;
        b_rdata  = b_rvalid ? r_data : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lk      <= LK_NONE;
            last    <= 1'b1;
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            rd_pend <= r_en;
            if (r_en) rd_port <= b_gnt;
            if (gnt) begin
                last <= b_gnt;
                lk   <= lock ? (b_gnt ? LK_B : LK_A) : LK_NONE;
            end
        end
    end
`ifdef MEM_PORT_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflicts  <= '0;
            perf_lock_stall <= '0;
        end else begin
            if (a_req && b_req && lk == LK_NONE && perf_conflicts != '1)
                perf_conflicts <= perf_conflicts + 32'd1;
            if (((lk == LK_A && b_req) || (lk == LK_B && a_req)) && perf_lock_stall != '1)
                perf_lock_stall <= perf_lock_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test-plan sequences plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    logic clk = 0, rst = 1;
    logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic a_gnt, a_rvalid, b_gnt, b_rvalid, r_en, w_en;
    logic [31:0] a_rdata, b_rdata, r_addr, r_data, w_addr, w_data;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_lock_stall;
`endif
    int n_cmp = 0, n_bad = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    // model: owner 0=none 1=A 2=B, last_p 0=A 1=B
    int owner = 0, last_p = 1, pend_port = 0, conf = 0, stall = 0;
    bit pend = 0, ea, eb;
    logic [31:0] pend_data;
    logic s_a_gnt, s_b_gnt, s_r_en, s_a_rvalid;
    logic [31:0] s_r_addr, s_a_rdata, s_b_rdata;

    mem_port_arbiter dut (
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_conflicts(perf_conflicts), .perf_lock_stall(perf_lock_stall),
`endif
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) mem[w_addr[7:0]] <= w_data;
        if (r_en) r_data <= mem[r_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wd);
        a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wd);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
    endtask

    // One clock: predict and compare at negedge, advance the model at posedge.
    task automatic cycle();
        bit g, gwe, arv, brv;
        logic [31:0] gaddr, gwd;
        int p;
        @(negedge clk);
        if (rst) begin ea = 0; eb = 0; end
        else if (owner == 1) begin ea = a_req; eb = 0; end
        else if (owner == 2) begin ea = 0; eb = b_req; end
        else if (a_req && b_req) begin ea = (last_p == 1); eb = !ea; end
        else begin ea = a_req; eb = b_req; end
        g = ea || eb;
        p = eb ? 1 : 0;
        gwe = eb ? b_we : a_we;
        gaddr = eb ? b_addr : a_addr;
        gwd = eb ? b_wdata : a_wdata;
        arv = !rst && pend && pend_port == 0;
        brv = !rst && pend && pend_port == 1;
        check("a_gnt", a_gnt, ea);
        check("b_gnt", b_gnt, eb);
        check("r_en", r_en, g && !gwe);
        check("w_en", w_en, g && gwe);
        check("r_addr", r_addr, (g && !gwe) ? gaddr : 0);
        check("w_addr", w_addr, (g && gwe) ? gaddr : 0);
        check("w_data", w_data, (g && gwe) ? gwd : 0);
        check("a_rvalid", a_rvalid, arv);
        check("b_rvalid", b_rvalid, brv);
        check("a_rdata", a_rdata, arv ? pend_data : 0);
        check("b_rdata", b_rdata, brv ? pend_data : 0);
`ifdef MEM_PORT_ARB_PERF_EN
        check("perf_conflicts", perf_conflicts, conf);
        check("perf_lock_stall", perf_lock_stall, stall);
`endif
        s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_r_en = r_en; s_r_addr = r_addr;
        s_a_rvalid = a_rvalid; s_a_rdata = a_rdata; s_b_rdata = b_rdata;
        @(posedge clk);
        if (rst) begin
            owner = 0; last_p = 1; pend = 0; conf = 0; stall = 0;
        end else begin
            if (a_req && b_req && owner == 0) conf++;
            if ((owner == 1 && b_req) || (owner == 2 && a_req)) stall++;
            pend = 0;
            if (g) begin
                if (gwe) ref_mem[gaddr[7:0]] = gwd;
                else begin pend = 1; pend_port = p; pend_data = ref_mem[gaddr[7:0]]; end
                owner = (eb ? b_lock : a_lock) ? p + 1 : 0;
                last_p = p;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        poke(16, 32'hDEADBEEF);
        cycle(); cycle();
        check("reset_gnt", {s_a_gnt, s_b_gnt, s_r_en}, 0);
`ifdef MEM_PORT_ARB_PERF_EN
        check("perf_reset", perf_conflicts | perf_lock_stall, 0);
`endif
        rst = 0;
        // single A read
        set_a(1, 0, 0, 32'h10, 0);
        cycle();
        check("plan1_gnt", {s_a_gnt, s_r_en}, 2'b11);
        check("plan1_raddr", s_r_addr, 32'h10);
        set_a(0, 0, 0, 0, 0);
        cycle();
        check("plan1_rdata", s_a_rdata, 32'hDEADBEEF);
        // alternating grants after reset
        rst = 1; cycle(); rst = 0;
        set_a(1, 0, 0, 32'h4, 0);
        set_b(1, 0, 0, 32'h8, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("plan2_alt", s_a_gnt, (i % 2) == 0);
        end
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        cycle();
        check("plan2_last_b", s_b_rdata, ref_mem[8]);
        // lock sequence, with last = A so B wins the first tie
        set_a(1, 0, 0, 32'h0, 0); cycle();
        set_a(1, 0, 0, 32'h40, 0);
        set_b(1, 1, 1, 32'h20, 32'h12345678); cycle();
        check("plan3_deny1", s_a_gnt, 0);
        set_b(1, 0, 0, 32'h20, 0); cycle();
        check("plan3_deny2", s_a_gnt, 0);
        set_b(0, 0, 0, 0, 0); cycle();
        check("plan3_a_gnt", s_a_gnt, 1);
        check("plan3_b_rdata", s_b_rdata, 32'h12345678);
        set_a(0, 0, 0, 0, 0); cycle();
        // reset right after a granted read
        set_a(1, 0, 0, 32'h0, 0); cycle();
        set_a(0, 0, 0, 0, 0); rst = 1; cycle();
        check("plan4_rv_rst", s_a_rvalid, 0);
        rst = 0; cycle();
        check("plan4_rv_after", s_a_rvalid, 0);
        set_a(1, 0, 0, 32'h4, 0); set_b(1, 0, 0, 32'h8, 0); cycle();
        check("plan4_tie_a", s_a_gnt, 1);
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); cycle();
        check("plan5_idle", {s_a_gnt, s_b_gnt, s_r_en}, 0);
        // write from B then read from A on consecutive cycles
        set_b(1, 1, 0, 32'h30, 32'hA5A5A5A5); cycle();
        set_b(0, 0, 0, 0, 0); set_a(1, 0, 0, 32'h30, 0); cycle();
        set_a(0, 0, 0, 0, 0); cycle();
        check("plan5_rdata", s_a_rdata, 32'hA5A5A5A5);
        // random traffic; requesters hold their request until granted
        for (int i = 0; i < 3000; i++) begin
            if (!a_req || ea)
                set_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                      {24'h0, 8'($urandom_range(0, 15))}, $urandom);
            if (!b_req || eb)
                set_b($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                      {24'h0, 8'($urandom_range(0, 15))}, $urandom);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory instance (1-cycle synchronous read, separate read/write address buses) between two requesters.
- Port A is the core data bus. Port B is an auxiliary master (program loader / debug access).
- Sits between the requesters and the memory instance in the top level.
- Fair round-robin arbitration, optional ownership lock for multi-cycle sequences, per-port read-return tagging.

Parameters:
ADDR_W, 32, address width of ports and memory side
DATA_W, 32, data width of ports and memory side

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous reset, active-high
a_req  in  1  port A requests one access this cycle
a_we  in  1  port A: 1 = write, 0 = read
a_lock  in  1  port A: keep ownership after this grant
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  port A access accepted this cycle (combinational)
a_rvalid  out  1  port A read data valid
a_rdata  out  DATA_W  port A read data
b_req, b_we, b_lock, b_addr, b_wdata  in  as port A  port B request
b_gnt, b_rvalid, b_rdata  out  as port A  port B response
r_en  out  1  memory read enable
r_addr  out  ADDR_W  memory read address
r_data  in  DATA_W  memory read data, valid cycle after r_en
w_en  out  1  memory write enable
w_addr  out  ADDR_W  memory write address
w_data  out  DATA_W  memory write data

Behaviour:
- One access per cycle total. The granted port drives the memory combinationally in the same cycle.
- Granted read: r_en=1, r_addr=addr. Granted write: w_en=1, w_addr=addr, w_data=wdata.
- Non-granted cycle: r_en=w_en=0; addresses/data driven 0.
- Handshake: access completes when req && gnt at a rising edge. A requester holds req/we/addr/wdata stable until gnt. gnt never asserts without req.
- Read return: exactly 1 cycle after a granted read, the owning port's rvalid=1 and rdata=r_data.
  - Tag register (rd_pend, rd_port) records the owner.
  - Other port's rvalid=0; rdata is driven 0 whenever rvalid=0.
- Back-to-back reads from either/alternating ports are sustained every cycle.
- Arbitration state: last (port last granted, reset = B); owner lock state LK_NONE / LK_A / LK_B (reset LK_NONE).
  - LK_NONE, one requester: grant it.
  - LK_NONE, both requesting: grant the port != last.
  - LK_A: only A may be granted; b_gnt=0 even if A idle. LK_B symmetric.
- Lock transitions, evaluated on a granted access:
  - lock=1 -> LK_<port>.
  - lock=0 -> LK_NONE (the unlocking access itself completes).
  - last updated on every grant.
- Reset mid-operation: state cleared on the next edge; pending read return dropped (rvalid=0 cycle after reset). While rst=1, both gnt=0 and r_en=w_en=0.
- Write then read of the same address from different ports on consecutive cycles returns the new data (memory write-first is not required; ordering is by grant cycle).

Optional Feature:
- Macro MEM_PORT_ARB_PERF_EN.
- Defined: adds outputs perf_conflicts (32 bits) and perf_lock_stall (32 bits).
  - perf_conflicts increments each cycle both req=1 and not in a lock state.
  - perf_lock_stall increments each cycle a non-owner req is denied by lock.
  - Both are saturating and cleared by rst.
- Undefined: outputs and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then A read of 0x10 (mem[0x10]=0xDEADBEEF) -> a_gnt=1 same cycle, r_en=1, r_addr=0x10; next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0.
- Both req (A read 0x4, B read 0x8) held 4 cycles after reset -> grants A,B,A,B; rvalid/rdata alternate on matching ports one cycle later.
- B write 0x20=0x12345678 with b_lock=1, then B read 0x20 with b_lock=0 while A requests throughout -> A denied 2 cycles; B read returns 0x12345678; A granted on cycle 3.
- A read 0x0 granted and rst asserted the following cycle -> a_rvalid=0 in that and the next cycle; last=B, lock cleared; next conflict grants A.
- Idle (no req) -> r_en=w_en=0, gnt=0; B write 0x30=0xA5A5A5A5 then A read 0x30 next cycle -> a_rdata=0xA5A5A5A5.
- MEM_PORT_ARB_PERF_EN defined: 3 conflict cycles + 2 lock-denied cycles -> perf_conflicts=3, perf_lock_stall=2; rst -> both 0.
